// File: rtl/l2_mesi_set_engine.sv
// L2 tag/MESI/LRU set engine: one processor or snoop command per IDLE->LOOK->UPD transaction.
// Optional hit/miss statistics counters are built when L2_STATS_EN is defined.
module l2_mesi_set_engine #(
    parameter int unsigned ASSOC = 8,
    parameter int unsigned SETS  = 16,
    parameter int unsigned TAG_W = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [3:0]               req_cmd,
    input  logic [$clog2(SETS)-1:0]  req_index,
    input  logic [TAG_W-1:0]         req_tag,
    input  logic [1:0]               bus_snp_res,
    output logic                     rsp_valid,
    output logic                     rsp_hit,
    output logic [$clog2(ASSOC)-1:0] rsp_way,
    output logic [2:0]               rsp_busop,
    output logic [1:0]               rsp_snoop,
    output logic                     rsp_wb,
    output logic [TAG_W-1:0]         rsp_wb_tag,
    output logic [31:0]              stat_hits,
    output logic [31:0]              stat_misses
);
    localparam int unsigned WAY_W = $clog2(ASSOC);
    localparam int unsigned IDX_W = $clog2(SETS);

    typedef enum logic [1:0] {ST_IDLE, ST_LOOK, ST_UPD, ST_CLEAR} fsm_t;
    typedef enum logic [1:0] {MESI_INV, MESI_SHRD, MESI_EXCL, MESI_MOD} mesi_t;
    typedef enum logic [3:0] {
        CMD_RD_L1D   = 4'd0,
        CMD_WR_L1D   = 4'd1,
        CMD_RD_L1I   = 4'd2,
        CMD_SNP_INV  = 4'd3,
        CMD_SNP_RD   = 4'd4,
        CMD_SNP_WR   = 4'd5,
        CMD_SNP_RWIM = 4'd6,
        CMD_CLR      = 4'd8,
        CMD_DISP     = 4'd9
    } cmd_t;
    typedef enum logic [2:0] {BUS_NONE, BUS_READ, BUS_WRITE, BUS_INVALIDATE, BUS_RWIM} busop_t;
    typedef enum logic [1:0] {SNP_NOHIT, SNP_HIT, SNP_HITM} snoop_t;

    fsm_t             state;
    logic [3:0]       cmd_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] clr_idx;
    logic [TAG_W-1:0] tag_r;

    logic [TAG_W-1:0] line_tag [SETS][ASSOC];
    mesi_t            line_st  [SETS][ASSOC];
    logic [WAY_W-1:0] line_lru [SETS][ASSOC];

    logic             hit;
    logic             inv_found;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] vic_way;
    logic [WAY_W-1:0] acc_way;
    logic [WAY_W-1:0] acc_rank;
    mesi_t            cur_st;
    mesi_t            vic_st;
    logic [TAG_W-1:0] vic_tag;
    mesi_t            nxt_st;
    logic             wr_st;
    logic             is_proc;
    logic             hit_c;
    busop_t           busop_c;
    snoop_t           snoop_c;
    logic             wb_c;
    logic [TAG_W-1:0] wb_tag_c;
    logic             clr_last;

    // Tag compare and victim choice: lowest INV way first, LRU rank 0 otherwise.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        vic_way   = '0;
        for (int unsigned w = 0; w < ASSOC; w++) begin
            if (!hit && line_st[idx_q][WAY_W'(w)] != MESI_INV &&
                line_tag[idx_q][WAY_W'(w)] == tag_r) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && line_st[idx_q][WAY_W'(w)] == MESI_INV) begin
                inv_found = 1'b1;
                vic_way   = WAY_W'(w);
            end
        end
        if (!inv_found) begin
            for (int unsigned w = 0; w < ASSOC; w++) begin
                if (line_lru[idx_q][WAY_W'(w)] == '0)
                    vic_way = WAY_W'(w);
            end
        end
    end

    assign cur_st   = line_st[idx_q][hit_way];
    assign vic_st   = line_st[idx_q][vic_way];
    assign vic_tag  = line_tag[idx_q][vic_way];
    assign acc_rank = line_lru[idx_q][acc_way];
    assign clr_last = (clr_idx == IDX_W'(SETS - 1));

    always_comb begin
        acc_way  = hit_way;
        nxt_st   = cur_st;
        wr_st    = 1'b0;
        is_proc  = 1'b0;
        hit_c    = hit;
        busop_c  = BUS_NONE;
        snoop_c  = SNP_NOHIT;
        wb_c     = 1'b0;
        wb_tag_c = '0;
        case (cmd_q)
            CMD_RD_L1D, CMD_RD_L1I: begin
                is_proc = 1'b1;
                wr_st   = 1'b1;
                if (!hit) begin
                    acc_way  = vic_way;
                    nxt_st   = (bus_snp_res == SNP_HIT || bus_snp_res == SNP_HITM) ?
                               MESI_SHRD : MESI_EXCL;
                    busop_c  = BUS_READ;
                    wb_c     = (vic_st == MESI_MOD);
                    wb_tag_c = (vic_st == MESI_MOD) ? vic_tag : '0;
                end
            end
            CMD_WR_L1D: begin
                is_proc = 1'b1;
                wr_st   = 1'b1;
                nxt_st  = MESI_MOD;
                if (hit) begin
                    busop_c = (cur_st == MESI_SHRD) ? BUS_INVALIDATE : BUS_NONE;
                end else begin
                    acc_way  = vic_way;
                    busop_c  = BUS_RWIM;
                    wb_c     = (vic_st == MESI_MOD);
                    wb_tag_c = (vic_st == MESI_MOD) ? vic_tag : '0;
                end
            end
            CMD_SNP_RD, CMD_SNP_RWIM: begin
                if (hit) begin
                    wr_st    = 1'b1;
                    nxt_st   = (cmd_q == CMD_SNP_RD) ? MESI_SHRD : MESI_INV;
                    snoop_c  = (cur_st == MESI_MOD) ? SNP_HITM : SNP_HIT;
                    wb_c     = (cur_st == MESI_MOD);
                    wb_tag_c = (cur_st == MESI_MOD) ? tag_r : '0;
                end
            end
            CMD_SNP_INV: begin
                if (hit) begin
                    wr_st   = 1'b1;
                    nxt_st  = (cur_st == MESI_SHRD) ? MESI_INV : cur_st;
                    snoop_c = SNP_HIT;
                end
            end
            CMD_SNP_WR: begin
            end
            default: hit_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cmd_q      <= '0;
            idx_q      <= '0;
            clr_idx    <= '0;
            tag_r      <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_hit    <= 1'b0;
            rsp_way    <= '0;
            rsp_busop  <= '0;
            rsp_snoop  <= '0;
            rsp_wb     <= 1'b0;
            rsp_wb_tag <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < ASSOC; w++) begin
                    line_tag[IDX_W'(s)][WAY_W'(w)] <= '0;
                    line_st[IDX_W'(s)][WAY_W'(w)]  <= MESI_INV;
                    line_lru[IDX_W'(s)][WAY_W'(w)] <= WAY_W'(w);
                end
            end
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cmd_q     <= req_cmd;
                        idx_q     <= req_index;
                        tag_r     <= req_tag;
                        req_ready <= 1'b0;
                        clr_idx   <= '0;
                        state     <= (req_cmd == CMD_CLR) ? ST_CLEAR : ST_LOOK;
                    end
                end
                // Array update is committed on the edge into UPD so the response and
                // the new set contents become visible together.
                ST_LOOK: begin
                    state      <= ST_UPD;
                    rsp_valid  <= 1'b1;
                    rsp_hit    <= hit_c;
                    rsp_way    <= acc_way;
                    rsp_busop  <= busop_c;
                    rsp_snoop  <= snoop_c;
                    rsp_wb     <= wb_c;
                    rsp_wb_tag <= wb_tag_c;
                    if (wr_st)
                        line_st[idx_q][acc_way] <= nxt_st;
                    if (is_proc && !hit)
                        line_tag[idx_q][acc_way] <= tag_r;
                    if (is_proc) begin
                        for (int unsigned w = 0; w < ASSOC; w++) begin
                            if (WAY_W'(w) == acc_way)
                                line_lru[idx_q][WAY_W'(w)] <= WAY_W'(ASSOC - 1);
                            else if (line_lru[idx_q][WAY_W'(w)] > acc_rank)
                                line_lru[idx_q][WAY_W'(w)] <= line_lru[idx_q][WAY_W'(w)] - 1'b1;
                        end
                    end
                end
                ST_UPD: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
                ST_CLEAR: begin
                    for (int unsigned w = 0; w < ASSOC; w++) begin
                        line_st[clr_idx][WAY_W'(w)]  <= MESI_INV;
                        line_lru[clr_idx][WAY_W'(w)] <= WAY_W'(w);
                    end
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_last) begin
                        state      <= ST_UPD;
                        rsp_valid  <= 1'b1;
                        rsp_hit    <= 1'b0;
                        rsp_way    <= '0;
                        rsp_busop  <= BUS_NONE;
                        rsp_snoop  <= SNP_NOHIT;
                        rsp_wb     <= 1'b0;
                        rsp_wb_tag <= '0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef L2_STATS_EN
    logic [31:0] hits_q;
    logic [31:0] misses_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (state == ST_CLEAR && clr_last) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (state == ST_LOOK && is_proc) begin
            if (hit) begin
                if (hits_q != '1)
                    hits_q <= hits_q + 1'b1;
            end else begin
                if (misses_q != '1)
                    misses_q <= misses_q + 1'b1;
            end
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`else
    assign stat_hits   = '0;
    assign stat_misses = '0;
`endif

endmodule
